// File: rtl/vga_pmod_sniffer.sv
// Receive-side checker for the TinyVGA PMOD byte: recovers line/frame timing from sync
// leading edges, checksums the active area and captures one probed pixel per frame.
module vga_pmod_sniffer #(
  parameter int unsigned HS_ACTIVE_HIGH = 0,
  parameter int unsigned VS_ACTIVE_HIGH = 0,
  parameter int unsigned H_START        = 144,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_START        = 35,
  parameter int unsigned V_ACTIVE       = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pmod,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic [15:0] frame_sum,
  output logic        frame_done,
  output logic        locked,
  output logic [5:0]  probe_rgb
);

  localparam int unsigned HCW = 12;
  localparam int unsigned VCW = 11;
  localparam int unsigned SW  = 16;
  localparam int unsigned PW  = 6;

  localparam logic           HS_LVL    = 1'(HS_ACTIVE_HIGH);
  localparam logic           VS_LVL    = 1'(VS_ACTIVE_HIGH);
  localparam logic [7:0]     PMOD_IDLE = {~HS_LVL, 3'b000, ~VS_LVL, 3'b000};
  localparam logic [HCW-1:0] HCNT_MAX  = '1;
  localparam logic [VCW-1:0] VCNT_MAX  = '1;
  localparam logic [HCW-1:0] H_LO      = HCW'(H_START);
  localparam logic [HCW:0]   H_HI      = (HCW + 1)'(H_START + H_ACTIVE);
  localparam logic [VCW-1:0] V_LO      = VCW'(V_START);
  localparam logic [VCW:0]   V_HI      = (VCW + 1)'(V_START + V_ACTIVE);

  logic [7:0]     s1_q, s1_d, s2_q, s2_d;
  logic [HCW-1:0] hcnt_q, hcnt_d, h_total_q, h_total_d, prev_h_q, prev_h_d;
  logic [VCW-1:0] vcnt_q, vcnt_d, v_total_q, v_total_d, prev_v_q, prev_v_d;
  logic [SW-1:0]  sum_q, sum_d, frame_sum_q, frame_sum_d;
  logic [PW-1:0]  probe_q, probe_d;
  logic           frame_done_q, frame_done_d, locked_q, locked_d;

  logic           hs_edge, vs_edge, pix_active, probe_hit;
  logic [PW-1:0]  rgb6;
  logic [HCW-1:0] x_off;
  logic [VCW-1:0] y_off;

  // Edge detect on stage 1 vs stage 2; the pixel being accounted is the stage-2 one.
  always_comb begin
    hs_edge    = (s1_q[7] == HS_LVL) && (s2_q[7] != HS_LVL);
    vs_edge    = (s1_q[3] == VS_LVL) && (s2_q[3] != VS_LVL);
    rgb6       = {s2_q[0], s2_q[4], s2_q[1], s2_q[5], s2_q[2], s2_q[6]};
    x_off      = hcnt_q - H_LO;
    y_off      = vcnt_q - V_LO;
    pix_active = (hcnt_q >= H_LO) && ({1'b0, hcnt_q} < H_HI) &&
                 (vcnt_q >= V_LO) && ({1'b0, vcnt_q} < V_HI);
    probe_hit  = (x_off == HCW'(probe_x)) && (y_off == VCW'(probe_y));
  end

  always_comb begin
    s1_d         = pmod;
    s2_d         = s1_q;
    hcnt_d       = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HCW'(1);
    vcnt_d       = vcnt_q;
    sum_d        = sum_q;
    h_total_d    = h_total_q;
    v_total_d    = v_total_q;
    frame_sum_d  = frame_sum_q;
    frame_done_d = 1'b0;
    locked_d     = locked_q;
    probe_d      = probe_q;
    prev_h_d     = prev_h_q;
    prev_v_d     = prev_v_q;

    if (pix_active) begin
      sum_d = sum_q + SW'(rgb6);
      if (probe_hit) probe_d = rgb6;
    end

    // A saturated line count (hcnt stuck at max) wraps to 0 in h_total.
    if (hs_edge) begin
      h_total_d = hcnt_q + HCW'(1);
      hcnt_d    = '0;
      vcnt_d    = (vcnt_q == VCNT_MAX) ? vcnt_q : vcnt_q + VCW'(1);
    end else if (hcnt_d == HCNT_MAX) begin
      h_total_d = '0;
      locked_d  = 1'b0;
    end

    // Frame close sees this cycle's line update and pixel.
    if (vs_edge) begin
      v_total_d    = vcnt_d;
      frame_sum_d  = sum_d;
      sum_d        = '0;
      vcnt_d       = '0;
      frame_done_d = 1'b1;
      locked_d     = (h_total_d == prev_h_q) && (v_total_d == prev_v_q) &&
                     (h_total_d != '0) && (v_total_d != '0);
      prev_h_d     = h_total_d;
      prev_v_d     = v_total_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= PMOD_IDLE;
      s2_q         <= PMOD_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      sum_q        <= '0;
      h_total_q    <= '0;
      v_total_q    <= '0;
      frame_sum_q  <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      probe_q      <= '0;
      prev_h_q     <= '0;
      prev_v_q     <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      sum_q        <= sum_d;
      h_total_q    <= h_total_d;
      v_total_q    <= v_total_d;
      frame_sum_q  <= frame_sum_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      probe_q      <= probe_d;
      prev_h_q     <= prev_h_d;
      prev_v_q     <= prev_v_d;
    end
  end

  assign h_total    = h_total_q;
  assign v_total    = v_total_q;
  assign frame_sum  = frame_sum_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign probe_rgb  = probe_q;

endmodule

// File: tb/tb_vga_pmod_sniffer.sv
// Bench for vga_pmod_sniffer: a reduced-geometry VGA generator drives the PMOD byte and a
// frame model queues the expected results checked at every frame_done.
module tb_vga_pmod_sniffer;

  localparam int HT        = 100;
  localparam int VT        = 20;
  localparam int HS_W      = 8;
  localparam int VS_W      = 2;
  localparam int H_START   = 12;
  localparam int H_ACTIVE  = 80;
  localparam int V_START   = 3;
  localparam int V_ACTIVE  = 12;
  localparam int BLANK_CYC = 4200;

  typedef struct {
    int         h;
    int         v;
    logic [15:0] sum;
    logic [5:0] probe;
    logic       lock;
    bit         chk_h;
    bit         chk_v;
    bit         chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_d = 1'b0;
  logic [7:0]  pmod;
  logic [9:0]  probe_x, probe_y;
  logic [11:0] h_total;
  logic [10:0] v_total;
  logic [15:0] frame_sum;
  logic        frame_done, locked;
  logic [5:0]  probe_rgb;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         prev_h, prev_v, fsum;
  bit         known;
  logic [5:0] exp_probe;

  vga_pmod_sniffer #(
    .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(0),
    .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clk(clk), .rst(rst), .pmod(pmod), .probe_x(probe_x), .probe_y(probe_y),
    .h_total(h_total), .v_total(v_total), .frame_sum(frame_sum),
    .frame_done(frame_done), .locked(locked), .probe_rgb(probe_rgb)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Active-low sync pins; colour bits scattered as {hs,B0,G0,R0,vs,B1,G1,R1}.
  function automatic logic [7:0] pack(input bit hs, input bit vs, input logic [5:0] c);
    return {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
  endfunction

  function automatic logic [5:0] pix_val(input int pat, input int gh);
    case (pat)
      0:       return 6'h3F;
      1:       return 6'h00;
      default: return 6'(gh - H_START);
    endcase
  endfunction

  task automatic push_partial();
    exp_t e;
    e.h = 0; e.v = 0; e.sum = '0; e.probe = '0; e.lock = 1'b0;
    e.chk_h = 1'b0; e.chk_v = 1'b0; e.chk_data = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    sb_q.delete();
    known     = 1'b0;
    exp_probe = '0;
    push_partial();
  endtask

  task automatic do_reset(input bit chk_pending);
    if (chk_pending) check_val("sb_pending", sb_q.size(), 1);
    repeat (3) begin
      @(posedge clk); #1;
      pmod = pack(1'b0, 1'b0, 6'h00);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One frame: sync pulses start at (0,0); colour is driven in blanking too.
  task automatic drive_frame(input int htot, input int pat, input int rst_at);
    bit         rst_in;
    bit         act;
    logic [5:0] c;
    exp_t       e;
    rst_in = 1'b0;
    fsum   = 0;
    for (int gv = 0; gv < VT; gv++) begin
      for (int gh = 0; gh < htot; gh++) begin
        @(posedge clk); #1;
        c    = pix_val(pat, gh);
        pmod = pack(gh < HS_W, gv < VS_W, c);
        rst  = (gv * htot + gh == rst_at);
        if (rst) begin
          rst_in = 1'b1;
          model_reset();
        end
        act = (gh >= H_START) && (gh < H_START + H_ACTIVE) &&
              (gv >= V_START) && (gv < V_START + V_ACTIVE);
        if (act) begin
          fsum += int'(c);
          if ((gh - H_START == int'(probe_x)) && (gv - V_START == int'(probe_y)))
            exp_probe = c;
        end
      end
    end
    if (!rst_in) begin
      e.h = htot; e.v = VT; e.sum = 16'(fsum); e.probe = exp_probe;
      e.lock = known && (htot == prev_h) && (VT == prev_v);
      e.chk_h = 1'b1; e.chk_v = 1'b1; e.chk_data = 1'b1;
      sb_q.push_back(e);
      prev_h = htot;
      prev_v = VT;
      known  = 1'b1;
    end
  endtask

  // hsync held off: the pending frame loses its line length and lock.
  task automatic blank_hsync();
    exp_t e;
    e = sb_q.pop_back();
    e.chk_h = 1'b0;
    e.lock  = 1'b0;
    sb_q.push_back(e);
    known = 1'b0;
    repeat (BLANK_CYC) begin
      @(posedge clk); #1;
      pmod = pack(1'b0, 1'b0, 6'h15);
    end
    @(posedge clk); #2;
    check_val("blank_locked", int'(locked), 0);
    check_val("blank_h_total", int'(h_total), 0);
  endtask

  always @(posedge clk) rst_d <= rst;

  always @(negedge clk) begin
    if (rst_d) begin
      check_val("rst_h_total", int'(h_total), 0);
      check_val("rst_v_total", int'(v_total), 0);
      check_val("rst_frame_sum", int'(frame_sum), 0);
      check_val("rst_frame_done", int'(frame_done), 0);
      check_val("rst_locked", int'(locked), 0);
      check_val("rst_probe_rgb", int'(probe_rgb), 0);
    end else if (frame_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("fd_unexpected", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("fd_locked", int'(locked), int'(mon_e.lock));
        if (mon_e.chk_h) check_val("fd_h_total", int'(h_total), mon_e.h);
        if (mon_e.chk_v) check_val("fd_v_total", int'(v_total), mon_e.v);
        if (mon_e.chk_data) begin
          check_val("fd_frame_sum", int'(frame_sum), int'(mon_e.sum));
          check_val("fd_probe_rgb", int'(probe_rgb), int'(mon_e.probe));
        end
      end
    end
  end

  initial begin
    pmod      = pack(1'b0, 1'b0, 6'h00);
    probe_x   = '0;
    probe_y   = '0;
    known     = 1'b0;
    prev_h    = 0;
    prev_v    = 0;
    exp_probe = '0;

    // Solid white, lock at the third frame_done.
    do_reset(1'b0);
    repeat (3) drive_frame(HT, 0, -1);

    // All black.
    do_reset(1'b1);
    repeat (3) drive_frame(HT, 1, -1);

    // Ramp pattern with far-corner and interior probes.
    do_reset(1'b1);
    probe_x = 10'd79; probe_y = 10'd11;
    drive_frame(HT, 2, -1);
    probe_x = 10'd70; probe_y = 10'd7;
    repeat (2) drive_frame(HT, 2, -1);

    // One short-line frame after lock.
    do_reset(1'b1);
    repeat (2) drive_frame(HT, 0, -1);
    drive_frame(HT - 1, 0, -1);
    repeat (3) drive_frame(HT, 0, -1);

    // Missing hsync, then recovery.
    do_reset(1'b1);
    repeat (3) drive_frame(HT, 0, -1);
    blank_hsync();
    repeat (3) drive_frame(HT, 0, -1);

    // Reset pulse mid-frame.
    do_reset(1'b1);
    repeat (2) drive_frame(HT, 0, -1);
    drive_frame(HT, 0, 9 * HT + 50);
    repeat (3) drive_frame(HT, 0, -1);

    repeat (4) @(posedge clk);
    #2;
    check_val("sb_pending", sb_q.size(), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pmod_sniffer.md
Name: vga_pmod_sniffer

Overview:
- Receive-side checker for the TinyVGA PMOD byte driven by our VGA test designs: hsync, vsync and 2-bit R/G/B.
- Recovers line and frame timing from the sync edges and measures line length (clocks) and frame length (lines).
- Accumulates a 16-bit checksum of active-area pixels and captures one probed pixel per frame.
- Used in sim benches and as an on-chip loopback self-test; runs at the pixel clock, one pixel per clk.

Parameters:
- HS_ACTIVE_HIGH, 0, hsync asserted level (0 = active-low).
- VS_ACTIVE_HIGH, 0, vsync asserted level.
- H_START, 144, hcnt value of first active pixel (sync 96 + back porch 48).
- H_ACTIVE, 640, active pixels per line.
- V_START, 35, vcnt value of first active line.
- V_ACTIVE, 480, active lines per frame.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- pmod  in  8  {hsync, B0, G0, R0, vsync, B1, G1, R1}, bit 7 first.
- probe_x  in  10  active-area x of the pixel to capture.
- probe_y  in  10  active-area y of the pixel to capture.
- h_total  out  12  last measured clocks per line.
- v_total  out  11  last measured lines per frame.
- frame_sum  out  16  checksum of the last completed frame.
- frame_done  out  1  one-cycle pulse when a frame's results update.
- locked  out  1  timing stable across consecutive frames.
- probe_rgb  out  6  last captured probe pixel {R1,R0,G1,G0,B1,B0}.

Behaviour:
- Pixel mapping: rgb6 = {pmod[0],pmod[4],pmod[1],pmod[5],pmod[2],pmod[6]}. Sync asserted = pin equals the *_ACTIVE_HIGH level.
- Pipeline: pmod registered once (stage 1); previous stage-1 value registered for edge detect (stage 2).
  - Leading edge = transition from deasserted to asserted.
  - All outputs update 2 clocks after the edge appears on pmod.
- hcnt (12b): +1 per clk, saturates at 4095. On hsync leading edge: h_total <= hcnt+1, then hcnt <= 0.
- vcnt (11b): +1 per hsync leading edge, saturates at 2047.
- On vsync leading edge, in the same cycle:
  - v_total <= vcnt, where vcnt already includes a coincident hsync edge.
  - frame_sum <= sum, including the current pixel if it is active.
  - sum <= 0 and vcnt <= 0.
  - frame_done pulses for 1 cycle.
- Active pixel: H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE. Then x = hcnt-H_START, y = vcnt-V_START.
- Checksum: sum <= sum + {10'b0, rgb6} for each active pixel, modulo 2^16.
- Probe: when an active pixel has x==probe_x and y==probe_y, probe_rgb <= rgb6. Otherwise probe_rgb holds.
- locked:
  - At each frame_done, set to 1 if the new h_total and v_total equal the previous frame's values and both are nonzero; otherwise 0.
  - Cleared immediately when hcnt saturates at 4095 (no hsync); h_total <= 0 at the same time.
- Reset:
  - All outputs 0 and counters 0; stored previous-frame values 0.
  - Edge-detect history is loaded with the deasserted level, so a sync already asserted at reset release counts as a leading edge.
- Reset mid-frame: the first frame_done after release reports a partial frame. The next matching full frame is needed for lock, so locked rises at the 3rd frame_done at the earliest.
- Sync pulse width is not checked; only leading edges matter.

Test Plan:
1. Standard 640x480@60 timing (800x525), solid rgb6=0x3F -> h_total=800, v_total=525, frame_sum=0x5000. locked=0 after frame_done #1 and #2 (frame 1 partial), locked=1 at #3.
2. Same timing, all pixels black -> frame_sum=0x0000, locked=1 at frame_done #3.
3. Pattern rgb6 = x[5:0] -> frame_sum=0xA800. probe (639,479) -> probe_rgb=0x3F. probe (100,7) -> 0x24.
4. After lock, one frame with 799-clock lines -> that frame_done shows h_total=799 and locked=0. Restoring 800 re-locks at the 2nd following frame_done.
5. Hold hsync deasserted -> 4095 clocks after the last edge, locked=0 and h_total=0. Resuming hsync -> locked regained after two matching frames.
6. Assert rst for 1 cycle at mid-frame -> all outputs 0 next cycle. Lock sequence then follows scenario 1, starting from the first frame_done after reset.
